nw_rd_arbiter: RTL and testbench



---
 rtl/nw_rd_arbiter_pkg.sv | 16 +
 rtl/nw_rd_arbiter_if.sv | 20 ++
 rtl/nw_rd_arbiter_rr.sv | 30 +++
 rtl/nw_rd_arbiter.sv | 131 +++++++++++++
 tb/tb_nw_rd_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nw_rd_arbiter_pkg.sv
// Shared constants and the AR holding-register layout for the NW read arbiter.
package nw_pkg;
    localparam int BEAT_BYTES = 64;
    localparam int PAGE_BEATS = 64;
    localparam logic [2:0] AR_SIZE = 3'b110;

    localparam int REQ_S0 = 0;
    localparam int REQ_S1 = 1;

    typedef struct packed {
        logic [15:0] id;
        logic [63:0] addr;
        logic [7:0]  arlen;
        logic        last;
    } ar_reg_t;
endpackage

// File: rtl/nw_rd_arbiter_if.sv
// AXI read-address channel plus the R-channel ID/valid used for steering.
interface nw_rd_arbiter_if;
    logic [15:0] arid_m;
    logic [63:0] araddr_m;
    logic [7:0]  arlen_m;
    logic [2:0]  arsize_m;
    logic        arvalid_m;
    logic        arready_m;
    logic [15:0] rid_m;
    logic        rvalid_m;

    modport master (
        output arid_m, araddr_m, arlen_m, arsize_m, arvalid_m,
        input  arready_m, rid_m, rvalid_m
    );
    modport slave (
        input  arid_m, araddr_m, arlen_m, arsize_m, arvalid_m,
        output arready_m, rid_m, rvalid_m
    );
endinterface

// File: rtl/nw_rd_arbiter_rr.sv
// Round-robin grant: searches from the entry after i_ptr; pointer moves to the winner on i_adv.
module rr_arbiter #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_elig,
    input  logic [PW-1:0] i_ptr,
    input  logic          i_adv,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_ptr_next
);
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_gidx;

    always_comb begin
        o_grant = '0;
        w_gidx  = i_ptr;
        w_idx   = '0;
        // Walk from farthest to nearest so the nearest eligible entry overwrites the rest.
        for (int k = N; k >= 1; k--) begin
            w_idx = PW'((int'(i_ptr) + k) % N);
            if (i_elig[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                w_gidx         = w_idx;
            end
        end
        o_ptr_next = (i_adv && (|i_elig)) ? w_gidx : i_ptr;
    end
endmodule

// File: rtl/nw_rd_arbiter.sv
// Shares one AXI AR channel between N_REQ streams: page-safe burst split, credit gating, RR grant.
module nw_rd_arbiter
    import nw_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int CREDIT_W    = 16,
    parameter int INIT_CREDIT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [64*N_REQ-1:0]   req_addr,
    input  logic [32*N_REQ-1:0]   req_words,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      req_done,
    input  logic [N_REQ-1:0]      fifo_pop,
    input  logic                  cred_wr,
    input  logic [7:0]            cred_idx,
    input  logic [CREDIT_W-1:0]   cred_data,
    nw_rd_arbiter_if.master       axi,
    output logic [N_REQ-1:0]      r_sel,
    output logic                  err_rid
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] w_elig, w_grant, w_zero, w_busy;
    logic [63:0]      w_addr  [N_REQ];
    logic [31:0]      w_words [N_REQ];
    logic [6:0]       w_len   [N_REQ];
    logic [PW-1:0]    w_ptr_next;
    logic             w_load, w_hs;

    ar_reg_t          r_ar;
    logic             r_arvalid;
    logic [PW-1:0]    r_ptr;
    logic [N_REQ-1:0] r_done;
    logic             r_err;

    assign w_hs   = r_arvalid && axi.arready_m;
    assign w_load = (!r_arvalid || axi.arready_m) && (|w_elig);

    rr_arbiter #(.N(N_REQ)) u_rr (
        .i_elig     (w_elig),
        .i_ptr      (r_ptr),
        .i_adv      (w_load),
        .o_grant    (w_grant),
        .o_ptr_next (w_ptr_next)
    );

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            logic                r_busy;
            logic [63:0]         r_addr;
            logic [31:0]         r_words;
            logic [CREDIT_W-1:0] r_credit;
            logic [6:0]          w_room;
            logic                w_take;

            // Beats left before the next 4 KB boundary; always 1..64.
            assign w_room      = 7'(PAGE_BEATS) - {1'b0, r_addr[11:6]};
            assign w_len[gi]   = (r_words < 32'(w_room)) ? r_words[6:0] : w_room;
            assign w_elig[gi]  = r_busy && (r_credit >= CREDIT_W'(w_len[gi]));
            assign w_zero[gi]  = req_valid[gi] && !r_busy && (req_words[32*gi +: 32] == 32'd0);
            assign w_take      = w_load && w_grant[gi];
            assign w_busy[gi]  = r_busy;
            assign w_addr[gi]  = r_addr;
            assign w_words[gi] = r_words;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_busy   <= 1'b0;
                    r_addr   <= '0;
                    r_words  <= '0;
                    r_credit <= CREDIT_W'(INIT_CREDIT);
                end else begin
                    if (cred_wr && (cred_idx == 8'(gi)))
                        r_credit <= cred_data;
                    else
                        r_credit <= r_credit - (w_take ? CREDIT_W'(w_len[gi]) : '0)
                                             + CREDIT_W'(fifo_pop[gi]);

                    if (w_take) begin
                        r_addr  <= r_addr + 64'(w_len[gi]) * 64'(BEAT_BYTES);
                        r_words <= r_words - 32'(w_len[gi]);
                        if (r_words == 32'(w_len[gi]))
                            r_busy <= 1'b0;
                    end else if (req_valid[gi] && !r_busy && !w_zero[gi]) begin
                        r_addr  <= req_addr[64*gi +: 64];
                        r_words <= req_words[32*gi +: 32];
                        r_busy  <= 1'b1;
                    end
                end
            end

            assign r_sel[gi] = axi.rvalid_m && (axi.rid_m == 16'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ar      <= '0;
            r_arvalid <= 1'b0;
            r_ptr     <= PW'(N_REQ - 1);
            r_done    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_done <= w_zero | ((w_hs && r_ar.last) ? (N_REQ'(1) << r_ar.id) : '0);
            if (w_load) begin
                r_arvalid  <= 1'b1;
                r_ar.id    <= 16'(w_ptr_next);
                r_ar.addr  <= w_addr[w_ptr_next];
                r_ar.arlen <= 8'(w_len[w_ptr_next]) - 8'd1;
                r_ar.last  <= (w_words[w_ptr_next] == 32'(w_len[w_ptr_next]));
                r_ptr      <= w_ptr_next;
            end else if (w_hs) begin
                r_arvalid  <= 1'b0;
            end
            if (axi.rvalid_m && (axi.rid_m >= 16'(N_REQ)))
                r_err <= 1'b1;
        end
    end

    assign req_ready     = ~w_busy;
    assign req_done      = r_done;
    assign err_rid       = r_err;
    assign axi.arid_m    = r_ar.id;
    assign axi.araddr_m  = r_ar.addr;
    assign axi.arlen_m   = r_ar.arlen;
    assign axi.arsize_m  = AR_SIZE;
    assign axi.arvalid_m = r_arvalid;
endmodule

// File: tb/tb_nw_rd_arbiter.sv
// Directed bench for nw_rd_arbiter: expected AR bursts queued at stimulus, checked at handshake.
module tb_nw_rd_arbiter;
    import nw_pkg::*;
    localparam int N = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_done, fifo_pop, r_sel;
    logic [64*N-1:0] req_addr;
    logic [32*N-1:0] req_words;
    logic            cred_wr, err_rid;
    logic [7:0]      cred_idx;
    logic [15:0]     cred_data;

    nw_rd_arbiter_if axi ();

    nw_rd_arbiter #(.N_REQ(N), .CREDIT_W(16), .INIT_CREDIT(256)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_words(req_words), .req_ready(req_ready), .req_done(req_done),
        .fifo_pop(fifo_pop), .cred_wr(cred_wr), .cred_idx(cred_idx),
        .cred_data(cred_data), .axi(axi), .r_sel(r_sel), .err_rid(err_rid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] id;
        logic [63:0] addr;
        logic [7:0]  arlen;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt[N];
    int   exp_done[N];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every AR handshake must match the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++)
                if (req_done[i]) done_cnt[i]++;
            if (axi.arvalid_m && axi.arready_m) begin
                $display("[TB] AR id=%0d addr=%h arlen=%0d", axi.arid_m, axi.araddr_m, axi.arlen_m);
                check("ar_expected", 128'(q.size() != 0), 128'(1));
                check("arsize", 128'(axi.arsize_m), 128'(AR_SIZE));
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("ar_fields", 128'({axi.arid_m, axi.araddr_m, axi.arlen_m}), 128'(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [63:0] a, input int arlen);
        q.push_back('{id: 16'(id), addr: a, arlen: 8'(arlen)});
    endtask

    task automatic send_desc(input int i, input logic [63:0] a, input logic [31:0] w, input bit counts);
        check("req_ready_before_desc", 128'(req_ready[i]), 128'(1));
        req_valid[i]          = 1'b1;
        req_addr[64*i +: 64]  = a;
        req_words[32*i +: 32] = w;
        tick();
        req_valid[i] = 1'b0;
        if (counts) exp_done[i]++;
    endtask

    task automatic cred_set(input int i, input int v);
        cred_wr   = 1'b1;
        cred_idx  = 8'(i);
        cred_data = 16'(v);
        tick();
        cred_wr = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q.size() != 0 || axi.arvalid_m) && n < 1000) begin
            tick();
            n++;
        end
        check({tag, "_drain_timeout"}, 128'(n < 1000), 128'(1));
        tick();
        tick();
    endtask

    task automatic check_done(input string tag);
        for (int i = 0; i < N; i++)
            check({tag, "_done_count"}, 128'(done_cnt[i]), 128'(exp_done[i]));
    endtask

    task automatic expect_stall(input string tag, input int cycles);
        repeat (cycles) tick();
        @(negedge clk);
        check({tag, "_arvalid_low"}, 128'(axi.arvalid_m), 128'(0));
        tick();
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; req_words = '0; fifo_pop = '0;
        cred_wr = 1'b0; cred_idx = '0; cred_data = '0;
        axi.arready_m = 1'b1; axi.rid_m = '0; axi.rvalid_m = 1'b0;
        for (int i = 0; i < N; i++) begin done_cnt[i] = 0; exp_done[i] = 0; end
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_arvalid", 128'(axi.arvalid_m), 128'(0));
        check("rst_req_ready", 128'(req_ready), 128'(2'b11));
        check("rst_req_done", 128'(req_done), 128'(0));
        check("rst_err_rid", 128'(err_rid), 128'(0));
        check("rst_ar_fields", 128'({axi.arid_m, axi.araddr_m, axi.arlen_m}), 128'(0));
        tick();

        // 100 beats from 0: split 64 + 36, credit 256 -> 156.
        push(0, 64'h0, 63); push(0, 64'h1000, 35);
        send_desc(0, 64'h0, 100, 1'b1);
        @(negedge clk);
        check("latency_arvalid_low", 128'(axi.arvalid_m), 128'(0));
        drain("t1");
        check_done("t1");

        // Exactly 156 credits left: consumed in full, then one more beat needs a pop.
        push(0, 64'h0, 63); push(0, 64'h1000, 63); push(0, 64'h2000, 27);
        send_desc(0, 64'h0, 156, 1'b1);
        drain("probe156");
        push(0, 64'h40000, 0);
        send_desc(0, 64'h40000, 1, 1'b1);
        expect_stall("probe_zero_credit", 4);
        fifo_pop[0] = 1'b1; tick(); fifo_pop[0] = 1'b0;
        drain("probe_pop");

        // Credit 10, 64-beat burst waits for 54 pops.
        cred_set(0, 10);
        push(0, 64'h0, 63);
        send_desc(0, 64'h0, 64, 1'b1);
        expect_stall("cred10", 5);
        fifo_pop[0] = 1'b1;
        repeat (53) tick();
        @(negedge clk);
        check("cred63_arvalid_low", 128'(axi.arvalid_m), 128'(0));
        tick();
        fifo_pop[0] = 1'b0;
        drain("cred64");
        push(0, 64'h80000, 0);
        send_desc(0, 64'h80000, 1, 1'b1);
        expect_stall("cred0_after_64", 4);
        cred_set(0, 256);
        drain("cred_restore");
        check_done("t3");

        // Page-crossing split on requester 1, then a zero-length descriptor.
        push(1, 64'h1FC0, 0); push(1, 64'h2000, 1);
        send_desc(1, 64'h1FC0, 3, 1'b1);
        drain("t2");
        send_desc(1, 64'h0, 0, 1'b1);
        @(negedge clk);
        check("zero_desc_done", 128'(req_done), 128'(2'b10));
        tick(); tick();
        check_done("t2");

        // Both requesters, 3 bursts each, alternating grants starting at 0.
        for (int b = 0; b < 3; b++) begin
            push(0, 64'h0 + 64'(b) * 64'h1000, 63);
            push(1, 64'h10000 + 64'(b) * 64'h1000, 63);
        end
        req_valid = 2'b11;
        req_addr  = {64'h10000, 64'h0};
        req_words = {32'd192, 32'd192};
        tick();
        req_valid = '0;
        exp_done[0]++; exp_done[1]++;
        drain("t4");
        check_done("t4");

        // Stall: AR fields hold for 5 cycles; pops during the stall still count.
        axi.arready_m = 1'b0;
        push(0, 64'h30000, 31);
        send_desc(0, 64'h30000, 32, 1'b1);
        fifo_pop[0] = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_fields", 128'({axi.arvalid_m, axi.arid_m, axi.araddr_m, axi.arlen_m}),
                  128'({1'b1, 16'd0, 64'h30000, 8'd31}));
            tick();
        end
        fifo_pop[0] = 1'b0;
        axi.arready_m = 1'b1;
        drain("t5_stall");
        push(0, 64'h31000, 35);
        send_desc(0, 64'h31000, 36, 1'b1);
        drain("t5_pop_credited");
        check_done("t5");

        // Reset with requester 1 mid-descriptor and an AR pending.
        axi.arready_m = 1'b0;
        send_desc(1, 64'h50FC0, 100, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst2_arvalid", 128'(axi.arvalid_m), 128'(0));
        check("rst2_req_ready", 128'(req_ready), 128'(2'b11));
        check("rst2_req_done", 128'(req_done), 128'(0));
        tick();
        axi.arready_m = 1'b1;
        for (int b = 0; b < 4; b++) push(0, 64'(b) * 64'h1000, 63);
        send_desc(0, 64'h0, 256, 1'b1);
        drain("rst2_credit256");
        push(0, 64'h100000, 0);
        send_desc(0, 64'h100000, 1, 1'b1);
        expect_stall("rst2_credit_exhausted", 4);
        cred_set(0, 1);
        drain("rst2_tail");
        check_done("t6");

        // R steering.
        axi.rvalid_m = 1'b1; axi.rid_m = 16'd0; #1;
        check("r_sel_id0", 128'(r_sel), 128'(2'b01));
        axi.rid_m = 16'd1; #1;
        check("r_sel_id1", 128'(r_sel), 128'(2'b10));
        axi.rid_m = 16'd5; #1;
        check("r_sel_id5", 128'(r_sel), 128'(2'b00));
        check("err_rid_before", 128'(err_rid), 128'(0));
        tick();
        axi.rvalid_m = 1'b0; axi.rid_m = 16'd0;
        @(negedge clk);
        check("err_rid_set", 128'(err_rid), 128'(1));
        tick(); tick();
        check("err_rid_sticky", 128'(err_rid), 128'(1));
        check("queue_empty_end", 128'(q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog_timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end
endmodule
